// File: rtl/alu_scan_pkg.sv
// rtl/alu_scan_pkg.sv - shared frame geometry, FSM state codes and funct3 values for the ALU scan master
package alu_scan_pkg;

  // Outbound frame: {op2, op1, w, funct3, ashr, sub}
  function automatic int frame_w(input int xlen);
    return 2 * xlen + 6;
  endfunction

  // Returned frame: {ltu, lt, eq, result}
  function automatic int rsp_w(input int xlen);
    return xlen + 3;
  endfunction

  // Field offsets inside the outbound frame (op2 sits at xlen+6)
  localparam int SUB_BIT    = 0;
  localparam int ASHR_BIT   = 1;
  localparam int FUNCT3_LSB = 2;
  localparam int W_BIT      = 5;
  localparam int OP1_LSB    = 6;

  function automatic int op2_lsb(input int xlen);
    return xlen + 6;
  endfunction

  // FSM state codes
  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] SHIFT   = 3'd1;
  localparam logic [2:0] SAMPLE  = 3'd2;
  localparam logic [2:0] SETTLE  = 3'd3;
  localparam logic [2:0] CAPTURE = 3'd4;
  localparam logic [2:0] DONE    = 3'd5;

  // ALU funct3 encodings
  localparam logic [2:0] F3_ADD  = 3'd0;
  localparam logic [2:0] F3_SLL  = 3'd1;
  localparam logic [2:0] F3_SLT  = 3'd2;
  localparam logic [2:0] F3_SLTU = 3'd3;
  localparam logic [2:0] F3_XOR  = 3'd4;
  localparam logic [2:0] F3_SR   = 3'd5;
  localparam logic [2:0] F3_OR   = 3'd6;
  localparam logic [2:0] F3_AND  = 3'd7;

endpackage

// File: rtl/alu_scan_master.sv
// rtl/alu_scan_master.sv - serialises one ALU request onto tdi, strobes sample, deserialises the tdo reply
module alu_scan_master
  import alu_scan_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int RX_LAT = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_sub,
  input  logic            req_ashr,
  input  logic [2:0]      req_funct3,
  input  logic            req_w,
  input  logic [XLEN-1:0] req_op1,
  input  logic [XLEN-1:0] req_op2,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_result,
  output logic            rsp_eq,
  output logic            rsp_lt,
  output logic            rsp_ltu,
  output logic            tdi,
  output logic            sample,
  input  logic            tdo,
  output logic            busy
);

  localparam int FRAME_W = frame_w(XLEN);
  localparam int RSP_W   = rsp_w(XLEN);
  localparam int CNT_W   = $clog2(FRAME_W + 1);

  localparam logic [CNT_W-1:0] SHIFT_LAST   = CNT_W'(FRAME_W - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(RX_LAT);
  localparam logic [CNT_W-1:0] CAPTURE_LAST = CNT_W'(RSP_W - 1);

  logic [2:0]         state;
  logic [CNT_W-1:0]   cnt;
  logic [FRAME_W-1:0] tx_sr;
  logic [RSP_W-1:0]   rx_sr;
  logic [FRAME_W-1:0] frame_in;
  logic               rx_en;
  logic               capture_done;

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign frame_in  = {req_op2, req_op1, req_w, req_funct3, req_ashr, req_sub};

  // Return bit 0 is on tdo during the last SETTLE cycle; bits 1..RSP_W-1 arrive
  // during CAPTURE counts 0..RSP_W-2. The final CAPTURE cycle only moves the
  // assembled word into the response registers.
  assign rx_en = ((state == SETTLE) && (cnt == SETTLE_LAST)) ||
                 ((state == CAPTURE) && (cnt != CAPTURE_LAST));
  assign capture_done = (state == CAPTURE) && (cnt == CAPTURE_LAST);

  // Phase sequencing, TX shift register and the registered tdi/sample pins
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      tx_sr  <= '0;
      tdi    <= 1'b0;
      sample <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            // MSB goes straight to the pin so it is on tdi during cycle 0
            state <= SHIFT;
            cnt   <= '0;
            tdi   <= frame_in[FRAME_W-1];
            tx_sr <= {frame_in[FRAME_W-2:0], 1'b0};
          end
        end
        SHIFT: begin
          if (cnt == SHIFT_LAST) begin
            state  <= SAMPLE;
            cnt    <= '0;
            tdi    <= 1'b0;
            sample <= 1'b1;
          end else begin
            cnt   <= cnt + 1'b1;
            tdi   <= tx_sr[FRAME_W-1];
            tx_sr <= {tx_sr[FRAME_W-2:0], 1'b0};
          end
        end
        SAMPLE: begin
          state  <= SETTLE;
          cnt    <= '0;
          sample <= 1'b0;
        end
        SETTLE: begin
          if (cnt == SETTLE_LAST) begin
            state <= CAPTURE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        CAPTURE: begin
          if (cnt == CAPTURE_LAST) begin
            state <= DONE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (rsp_ready) begin
            state <= IDLE;
            cnt   <= '0;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // RX deserialiser and the held response registers
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_sr      <= '0;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_eq     <= 1'b0;
      rsp_lt     <= 1'b0;
      rsp_ltu    <= 1'b0;
    end else begin
      if (rx_en) begin
        rx_sr <= {rx_sr[RSP_W-2:0], tdo};
      end
      if (capture_done) begin
        rsp_valid  <= 1'b1;
        rsp_ltu    <= rx_sr[RSP_W-1];
        rsp_lt     <= rx_sr[RSP_W-2];
        rsp_eq     <= rx_sr[RSP_W-3];
        rsp_result <= rx_sr[XLEN-1:0];
      end else if ((state == DONE) && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_scan_master.sv
// tb/tb_alu_scan_master.sv - scoreboard bench: two masters (RX_LAT 0 and 2) driving behavioural scan-ALU targets
module tb_alu_scan_master;

  localparam int XLEN    = 64;
  localparam int FRAME_W = 2 * XLEN + 6;
  localparam int RSP_W   = XLEN + 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic            req_valid  [2];
  logic            req_ready  [2];
  logic            req_sub    [2];
  logic            req_ashr   [2];
  logic [2:0]      req_funct3 [2];
  logic            req_w      [2];
  logic [XLEN-1:0] req_op1    [2];
  logic [XLEN-1:0] req_op2    [2];
  logic            rsp_valid  [2];
  logic            rsp_ready  [2];
  logic [XLEN-1:0] rsp_result [2];
  logic            rsp_eq     [2];
  logic            rsp_lt     [2];
  logic            rsp_ltu    [2];
  logic            tdi        [2];
  logic            sample     [2];
  logic            tdo        [2];
  logic            busy       [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    alu_scan_master #(.XLEN(XLEN), .RX_LAT(2 * g)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid[g]),
      .req_ready  (req_ready[g]),
      .req_sub    (req_sub[g]),
      .req_ashr   (req_ashr[g]),
      .req_funct3 (req_funct3[g]),
      .req_w      (req_w[g]),
      .req_op1    (req_op1[g]),
      .req_op2    (req_op2[g]),
      .rsp_valid  (rsp_valid[g]),
      .rsp_ready  (rsp_ready[g]),
      .rsp_result (rsp_result[g]),
      .rsp_eq     (rsp_eq[g]),
      .rsp_lt     (rsp_lt[g]),
      .rsp_ltu    (rsp_ltu[g]),
      .tdi        (tdi[g]),
      .sample     (sample[g]),
      .tdo        (tdo[g]),
      .busy       (busy[g])
    );
  end

  // Behavioural scan-ALU target: frame shifts in on tdi, result loads on sample
  function automatic logic [RSP_W-1:0] target_alu(input logic [FRAME_W-1:0] f);
    logic [63:0] a, b, r;
    logic [31:0] a32;
    logic [5:0]  sh;
    logic        sub, ashr, w;
    logic [2:0]  f3;
    sub = f[0]; ashr = f[1]; f3 = f[4:2]; w = f[5];
    a = f[69:6]; b = f[133:70]; a32 = a[31:0];
    sh = w ? {1'b0, b[4:0]} : b[5:0];
    case (f3)
      3'd0: r = sub ? a - b : a + b;
      3'd1: r = a << sh;
      3'd2: r = {63'd0, $signed(a) < $signed(b)};
      3'd3: r = {63'd0, a < b};
      3'd4: r = a ^ b;
      3'd5: begin
        if (w) r = ashr ? {32'd0, 32'($signed(a32) >>> sh)} : {32'd0, a32 >> sh};
        else   r = ashr ? 64'($signed(a) >>> sh) : a >> sh;
      end
      3'd6: r = a | b;
      default: r = a & b;
    endcase
    if (w) r = {{32{r[31]}}, r[31:0]};
    return {a < b, $signed(a) < $signed(b), a == b, r};
  endfunction

  logic [FRAME_W-1:0] frame_sr [2];
  logic [RSP_W-1:0]   out_sr   [2];
  logic               rx_p1    [2];
  logic               rx_p2    [2];

  // Target scan chains plus the two board flops on the RX_LAT=2 return path
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      frame_sr[d] <= {frame_sr[d][FRAME_W-2:0], tdi[d]};
      if (sample[d]) out_sr[d] <= target_alu(frame_sr[d]);
      else           out_sr[d] <= {out_sr[d][RSP_W-2:0], 1'b0};
      rx_p1[d] <= out_sr[d][RSP_W-1];
      rx_p2[d] <= rx_p1[d];
    end
  end
  assign tdo[0] = out_sr[0][RSP_W-1];
  assign tdo[1] = rx_p2[1];

  typedef struct {
    int          d;
    logic [63:0] res;
    logic [2:0]  flg;
  } exp_t;
  exp_t sb[$];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string nm, input int d, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d actual=%h required=%h (cycle %0d)", nm, d, act, exp, cyc);
    end
  endtask

  int   a_cyc    [2] = '{0, 0};
  int   hs_cyc   [2] = '{0, 0};
  logic held_hs  [2] = '{1'b0, 1'b0};
  logic prev_val [2] = '{1'b0, 1'b0};
  logic prev_smp [2] = '{1'b0, 1'b0};
  logic rst_seen = 1'b0;
  exp_t e;

  // Monitor: timing, reset state, stall stability and scoreboard compares
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst_seen && !rst) begin
        check("rst_tdi", d, 64'(tdi[d]), 64'd0);
        check("rst_sample", d, 64'(sample[d]), 64'd0);
        check("rst_rsp_valid", d, 64'(rsp_valid[d]), 64'd0);
        check("rst_busy", d, 64'(busy[d]), 64'd0);
        check("rst_req_ready", d, 64'(req_ready[d]), 64'd1);
        check("rst_rsp_result", d, rsp_result[d], 64'd0);
      end
      if (!rst) begin
        if (req_valid[d] && req_ready[d]) begin
          a_cyc[d] = cyc + 1;
          if (held_hs[d]) begin
            check("turnaround", d, 64'(a_cyc[d] - hs_cyc[d]), 64'd1);
            held_hs[d] = 1'b0;
          end
        end
        if (sample[d] && !prev_smp[d])
          check("sample_start", d, 64'(cyc - a_cyc[d]), 64'(FRAME_W));
        if (!sample[d] && prev_smp[d])
          check("sample_end", d, 64'(cyc - a_cyc[d]), 64'(FRAME_W + 1));
        if (rsp_valid[d]) begin
          if (!prev_val[d])
            check("rsp_valid_cycle", d, 64'(cyc - a_cyc[d]), 64'(FRAME_W + XLEN + 5 + 2 * d));
          else
            check("stall_req_ready", d, 64'(req_ready[d]), 64'd0);
          if (sb.size() == 0 || sb[0].d != d) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_rsp dut%0d actual=%h required=no response", d, rsp_result[d]);
          end else begin
            check("rsp_result", d, rsp_result[d], sb[0].res);
            check("rsp_flags", d, 64'({rsp_ltu[d], rsp_lt[d], rsp_eq[d]}), 64'(sb[0].flg));
            if (rsp_ready[d]) e = sb.pop_front();
          end
          if (rsp_ready[d]) begin
            hs_cyc[d]  = cyc + 1;
            held_hs[d] = req_valid[d];
          end
        end
      end
      prev_val[d] = rsp_valid[d];
      prev_smp[d] = sample[d];
    end
    rst_seen = rst;
  end

  task automatic send(input int d, input logic [63:0] o1, input logic [63:0] o2, input logic [2:0] f3,
                      input logic sub, input logic ashr, input logic w,
                      input logic [63:0] er, input logic [2:0] ef, input bit push);
    exp_t x;
    int   n;
    @(posedge clk); #1;
    req_op1[d] = o1; req_op2[d] = o2; req_funct3[d] = f3;
    req_sub[d] = sub; req_ashr[d] = ashr; req_w[d] = w;
    req_valid[d] = 1'b1;
    if (push) begin
      x.d = d; x.res = er; x.flg = ef;
      sb.push_back(x);
    end
    n = 0;
    while (!req_ready[d]) begin
      @(posedge clk); #1;
      n++;
      if (n > 2000) begin
        $display("FAIL req_accept_timeout dut%0d actual=never ready required=accept within 2000 cycles", d);
        $fatal(1, "request never accepted");
      end
    end
    @(posedge clk); #1;
    req_valid[d] = 1'b0;
    req_op1[d] = {$urandom, $urandom};
    req_op2[d] = {$urandom, $urandom};
    req_funct3[d] = 3'($urandom);
    req_sub[d] = 1'($urandom);
    req_ashr[d] = 1'($urandom);
    req_w[d] = 1'($urandom);
  endtask

  task automatic wait_idle(input int d);
    int n;
    n = 0;
    while (busy[d] || rsp_valid[d]) begin
      @(posedge clk); #1;
      n++;
      if (n > 2000) begin
        $display("FAIL idle_timeout dut%0d actual=busy required=idle within 2000 cycles", d);
        $fatal(1, "master never returned to idle");
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0; req_sub[d] = 1'b0; req_ashr[d] = 1'b0; req_funct3[d] = 3'd0;
      req_w[d] = 1'b0; req_op1[d] = '0; req_op2[d] = '0; rsp_ready[d] = 1'b1;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // ADD, SUB equal, signed vs unsigned compare, W add, SLL, AND
    send(0, 64'd5, 64'd7, 3'd0, 1'b0, 1'b0, 1'b0, 64'd12, 3'b110, 1'b1);
    wait_idle(0);
    send(0, 64'd7, 64'd7, 3'd0, 1'b1, 1'b0, 1'b0, 64'd0, 3'b001, 1'b1);
    wait_idle(0);
    send(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 3'd2, 1'b0, 1'b0, 1'b0, 64'd1, 3'b010, 1'b1);
    wait_idle(0);
    send(0, 64'h0000_0000_7FFF_FFFF, 64'd1, 3'd0, 1'b0, 1'b0, 1'b1, 64'hFFFF_FFFF_8000_0000, 3'b000, 1'b1);
    wait_idle(0);
    send(0, 64'd1, 64'd63, 3'd1, 1'b0, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 3'b110, 1'b1);
    wait_idle(0);
    send(0, 64'hF0F0, 64'hFF00, 3'd7, 1'b0, 1'b0, 1'b0, 64'hF000, 3'b110, 1'b1);
    wait_idle(0);

    // Backpressure: response stalled 20 cycles while the next request waits
    rsp_ready[0] = 1'b0;
    send(0, 64'd10, 64'd3, 3'd4, 1'b0, 1'b0, 1'b0, 64'd9, 3'b000, 1'b1);
    fork
      begin
        int n;
        n = 0;
        while (!rsp_valid[0] && n < 2000) begin
          @(posedge clk); #1;
          n++;
        end
        repeat (20) @(posedge clk);
        #1 rsp_ready[0] = 1'b1;
      end
    join_none
    send(0, 64'd12, 64'd3, 3'd6, 1'b0, 1'b0, 1'b0, 64'd15, 3'b000, 1'b1);
    wait_idle(0);

    // Reset around cycle 60 of SHIFT drops the op; a fresh op then completes
    send(0, 64'd1, 64'd1, 3'd0, 1'b0, 1'b0, 1'b0, 64'd2, 3'b001, 1'b0);
    repeat (59) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (250) @(posedge clk);
    send(0, 64'd3, 64'd4, 3'd0, 1'b0, 1'b0, 1'b0, 64'd7, 3'b110, 1'b1);
    wait_idle(0);

    // RX_LAT=2 instance: arithmetic shift right by 4
    send(1, 64'h8000_0000_0000_0000, 64'd4, 3'd5, 1'b0, 1'b1, 1'b0, 64'hF800_0000_0000_0000, 3'b010, 1'b1);
    wait_idle(1);

    repeat (5) @(posedge clk);
    if (sb.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL responses_missing actual=%0d outstanding required=0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
